pipe_stage_reg: RTL and testbench

//   Parametrised inter-stage pipeline register for the 5-stage core.
//   - Generalises the per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB): DEPTH back-to-back

---
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Holds DEPTH back-to-back slots of {valid, ctrl, halt, data} between two
// pipeline stages. Advance is qualified by en (cache hit). A hazard stall
// freezes every slot, and a flush kills every slot. A sticky halt flag
// latches once a HALT instruction reaches the last slot. The occupancy count
// is kept registered alongside the slots.
module pipe_stage_reg #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,
  parameter int DEPTH      = 1,
  parameter int FLUSH_DATA = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       valid_in,
  input  logic                       halt_in,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       valid_out,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [DATA_W-1:0]          data_out,
  output logic                       halt_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              r_valid [DEPTH];
  logic [CTRL_W-1:0] r_ctrl  [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic              r_halt  [DEPTH];
  logic              r_haltOut;
  logic [OCC_W-1:0]  r_occ;

  logic              w_nextValid [DEPTH];
  logic [CTRL_W-1:0] w_nextCtrl  [DEPTH];
  logic [DATA_W-1:0] w_nextData  [DEPTH];
  logic              w_nextHalt  [DEPTH];
  logic [OCC_W-1:0]  w_nextOcc;
  logic              w_haltArrives;

  // Next slot contents. Flush beats stall, and stall beats en. Slots hold by default.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nextValid[i] = r_valid[i];
      w_nextCtrl[i]  = r_ctrl[i];
      w_nextData[i]  = r_data[i];
      w_nextHalt[i]  = r_halt[i];
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_nextValid[i] = 1'b0;
        w_nextCtrl[i]  = '0;
        w_nextHalt[i]  = 1'b0;
        if (FLUSH_DATA != 0) begin
          w_nextData[i] = '0;
        end
      end
    end else if (!stall && en) begin
      for (int i = 1; i < DEPTH; i++) begin
        w_nextValid[i] = r_valid[i-1];
        w_nextCtrl[i]  = r_ctrl[i-1];
        w_nextData[i]  = r_data[i-1];
        w_nextHalt[i]  = r_halt[i-1];
      end
      w_nextValid[0] = valid_in;
      w_nextCtrl[0]  = valid_in ? ctrl_in : '0;
      w_nextData[0]  = data_in;
      w_nextHalt[0]  = halt_in & valid_in;
    end
  end

  // Occupancy of the next state, and whether a valid HALT lands in the last slot.
  always_comb begin
    w_nextOcc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_nextOcc = w_nextOcc + OCC_W'(w_nextValid[i]);
    end
    w_haltArrives = w_nextValid[DEPTH-1] & w_nextHalt[DEPTH-1];
  end

  // Slot registers. An asynchronous reset clears every slot immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctrl[i]  <= '0;
        r_data[i]  <= '0;
        r_halt[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= w_nextValid[i];
        r_ctrl[i]  <= w_nextCtrl[i];
        r_data[i]  <= w_nextData[i];
        r_halt[i]  <= w_nextHalt[i];
      end
    end
  end

  // Registered occupancy and sticky halt. Only reset clears the halt flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_occ     <= '0;
      r_haltOut <= 1'b0;
    end else begin
      r_occ     <= w_nextOcc;
      r_haltOut <= r_haltOut | w_haltArrives;
    end
  end

  // Outputs come from the last slot. ctrl is masked so a bubble never leaks control.
  always_comb begin
    valid_out = r_valid[DEPTH-1];
    ctrl_out  = r_valid[DEPTH-1] ? r_ctrl[DEPTH-1] : '0;
    data_out  = r_data[DEPTH-1];
    halt_out  = r_haltOut;
    occupancy = r_occ;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives three configurations of pipe_stage_reg with shared
// inputs. The configurations are (DEPTH=2, keep data), (DEPTH=3, clear data on
// flush) and (DEPTH=1, keep data). Each DUT is compared every cycle against an
// array-of-slots reference model. Directed checks cover the listed scenarios.
module tb_pipe_stage_reg;

  typedef struct {
    logic        v;
    logic [15:0] c;
    logic [63:0] d;
    logic        h;
  } slot_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        en = 1'b0, stall = 1'b0, flush = 1'b0, validIn = 1'b0, haltIn = 1'b0;
  logic [15:0] ctrlIn = '0;
  logic [63:0] dataIn = '0;

  logic        obsValid [3];
  logic [15:0] obsCtrl  [3];
  logic [63:0] obsData  [3];
  logic        obsHalt  [3];
  logic [63:0] obsOcc   [3];

  logic        validA, validB, validC, haltA, haltB, haltC;
  logic [15:0] ctrlA, ctrlB, ctrlC;
  logic [63:0] dataA, dataB, dataC;
  logic [1:0]  occA, occB;
  logic [0:0]  occC;

  slot_t mdl [3][4];
  logic  mHalt [3];

  int assertCount = 0;
  int failCount   = 0;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .DEPTH(2), .FLUSH_DATA(0)) uA (
    .CLK(CLK), .RST(RST), .en(en), .stall(stall), .flush(flush),
    .valid_in(validIn), .halt_in(haltIn), .ctrl_in(ctrlIn), .data_in(dataIn),
    .valid_out(validA), .ctrl_out(ctrlA), .data_out(dataA), .halt_out(haltA),
    .occupancy(occA));

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .DEPTH(3), .FLUSH_DATA(1)) uB (
    .CLK(CLK), .RST(RST), .en(en), .stall(stall), .flush(flush),
    .valid_in(validIn), .halt_in(haltIn), .ctrl_in(ctrlIn), .data_in(dataIn),
    .valid_out(validB), .ctrl_out(ctrlB), .data_out(dataB), .halt_out(haltB),
    .occupancy(occB));

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .DEPTH(1), .FLUSH_DATA(0)) uC (
    .CLK(CLK), .RST(RST), .en(en), .stall(stall), .flush(flush),
    .valid_in(validIn), .halt_in(haltIn), .ctrl_in(ctrlIn), .data_in(dataIn),
    .valid_out(validC), .ctrl_out(ctrlC), .data_out(dataC), .halt_out(haltC),
    .occupancy(occC));

  // Gather the DUT outputs into arrays indexed by configuration.
  always_comb begin
    obsValid[0] = validA; obsValid[1] = validB; obsValid[2] = validC;
    obsCtrl[0]  = ctrlA;  obsCtrl[1]  = ctrlB;  obsCtrl[2]  = ctrlC;
    obsData[0]  = dataA;  obsData[1]  = dataB;  obsData[2]  = dataC;
    obsHalt[0]  = haltA;  obsHalt[1]  = haltB;  obsHalt[2]  = haltC;
    obsOcc[0]   = 64'(occA);
    obsOcc[1]   = 64'(occB);
    obsOcc[2]   = 64'(occC);
  end

  function automatic int depthOf(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 1;
  endfunction

  function automatic bit clearsData(input int k);
    return (k == 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic s, input logic f, input logic v,
                               input logic h, input logic [15:0] c, input logic [63:0] d);
    en = e; stall = s; flush = f; validIn = v; haltIn = h; ctrlIn = c; dataIn = d;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mHalt[k] = 1'b0;
      for (int i = 0; i < 4; i++) mdl[k][i] = '{v: 1'b0, c: 16'h0, d: 64'h0, h: 1'b0};
    end
  endtask

  // The slots form a shift line. A new entry enters at index 0, and the oldest sits at depth-1.
  task automatic modelStep();
    for (int k = 0; k < 3; k++) begin
      int dep = depthOf(k);
      if (flush) begin
        for (int i = 0; i < dep; i++) begin
          mdl[k][i].v = 1'b0;
          mdl[k][i].c = 16'h0;
          mdl[k][i].h = 1'b0;
          if (clearsData(k)) mdl[k][i].d = 64'h0;
        end
      end else if (en && !stall) begin
        for (int i = dep - 1; i > 0; i--) mdl[k][i] = mdl[k][i-1];
        mdl[k][0] = '{v: validIn, c: (validIn ? ctrlIn : 16'h0), d: dataIn, h: haltIn & validIn};
        if (mdl[k][dep-1].v && mdl[k][dep-1].h) mHalt[k] = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 3; k++) begin
      int dep = depthOf(k);
      int cnt = 0;
      slot_t last = mdl[k][dep-1];
      for (int i = 0; i < dep; i++) cnt += int'(mdl[k][i].v);
      checkOutput($sformatf("valid_out[%0d]", k), 64'(obsValid[k]), 64'(last.v));
      checkOutput($sformatf("ctrl_out[%0d]", k), 64'(obsCtrl[k]), 64'(last.v ? last.c : 16'h0));
      checkOutput($sformatf("data_out[%0d]", k), obsData[k], last.d);
      checkOutput($sformatf("halt_out[%0d]", k), 64'(obsHalt[k]), 64'(mHalt[k]));
      checkOutput($sformatf("occupancy[%0d]", k), obsOcc[k], 64'(cnt));
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    modelStep();
    @(negedge CLK);
    checkAll();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    // The reset clears outputs with no clock edge.
    #1 RST = 1'b1;
    #1;
    checkOutput("reset valid_out", 64'(validA), 64'h0);
    checkOutput("reset occupancy", 64'(occA), 64'h0);
    checkOutput("reset halt_out", 64'(haltC), 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    checkAll();

    // Two-cycle latency through a DEPTH=2 register.
    applyStimulus(1, 0, 0, 1, 0, 16'h00A5, 64'h1234);
    cycle();
    checkOutput("push1 occupancy", 64'(occA), 64'h1);
    checkOutput("push1 valid_out", 64'(validA), 64'h0);
    applyStimulus(1, 0, 0, 1, 0, 16'h0011, 64'h5678);
    cycle();
    checkOutput("push2 occupancy", 64'(occA), 64'h2);
    checkOutput("push2 valid_out", 64'(validA), 64'h1);
    checkOutput("push2 ctrl_out", 64'(ctrlA), 64'h00A5);
    checkOutput("push2 data_out", dataA, 64'h1234);
    applyStimulus(1, 0, 0, 1, 0, 16'h0022, 64'h9ABC);
    cycle();
    checkOutput("push3 data_out B", dataB, 64'h1234);

    // A flush kills the full register. Data is kept or cleared per configuration.
    applyStimulus(1, 0, 1, 1, 0, 16'h0033, 64'hDEAD);
    cycle();
    checkOutput("flush valid_out", 64'(validA), 64'h0);
    checkOutput("flush ctrl_out", 64'(ctrlA), 64'h0);
    checkOutput("flush occupancy", 64'(occA), 64'h0);
    checkOutput("flush data kept A", dataA, 64'h5678);
    checkOutput("flush data cleared B", dataB, 64'h0);

    // A stall freezes everything despite en=1. After release, the pipe resumes.
    applyStimulus(1, 0, 0, 1, 0, 16'h0001, 64'hAAA0);
    cycle();
    applyStimulus(1, 0, 0, 1, 0, 16'h0002, 64'hAAA1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 16'h0003, 64'hBBB0 + 64'(i));
      cycle();
      checkOutput("stall data_out", dataA, 64'hAAA0);
      checkOutput("stall ctrl_out", 64'(ctrlA), 64'h0001);
      checkOutput("stall occupancy", 64'(occA), 64'h2);
    end
    applyStimulus(1, 0, 0, 1, 0, 16'h0004, 64'hCCC0);
    cycle();
    checkOutput("release data_out", dataA, 64'hAAA1);

    // Bubbles with ctrl_in all-ones must reach the output with ctrl zeroed.
    applyStimulus(1, 0, 0, 0, 0, 16'hFFFF, 64'h0F0F);
    cycle();
    checkOutput("bubble1 data_out", dataA, 64'hCCC0);
    checkOutput("bubble1 ctrl_out", 64'(ctrlA), 64'h0004);
    applyStimulus(1, 0, 0, 0, 0, 16'hFFFF, 64'h0F0F);
    cycle();
    checkOutput("bubble2 valid_out", 64'(validA), 64'h0);
    checkOutput("bubble2 ctrl_out", 64'(ctrlA), 64'h0);
    checkOutput("bubble2 occupancy", 64'(occA), 64'h0);

    // With en=0 nothing shifts.
    applyStimulus(1, 0, 0, 1, 0, 16'h0005, 64'hDDD0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 16'h0006, 64'hEEE0 + 64'(i));
      cycle();
      checkOutput("idle occupancy", 64'(occA), 64'h1);
      checkOutput("idle valid_out", 64'(validA), 64'h0);
    end

    // The sticky halt survives a flush. A mid-cycle reset clears it asynchronously.
    applyStimulus(1, 0, 0, 1, 1, 16'h0007, 64'h4A17);
    cycle();
    checkOutput("halt set C", 64'(haltC), 64'h1);
    applyStimulus(1, 0, 1, 1, 0, 16'h0008, 64'h0);
    cycle();
    checkOutput("halt after flush C", 64'(haltC), 64'h1);
    checkOutput("halt killed A", 64'(haltA), 64'h0);
    #2 RST = 1'b1;
    #1;
    checkOutput("async reset halt C", 64'(haltC), 64'h0);
    checkOutput("async reset valid C", 64'(validC), 64'h0);
    modelReset();
    #1 RST = 1'b0;

    // Randomised control against the reference model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 15),
                    ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 70),
                    ($urandom_range(0, 99) < 4), 16'($urandom), {$urandom, $urandom});
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
